// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the multi-level teeter game flow: state encodings,
// spawn point and screen geometry.
package game_flow_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESETING  = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_FAIL_HOLD = 3'd3,
        ST_WIN_HOLD  = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_COMPLETE  = 3'd6
    } state_t;

    localparam int SPAWN_X       = 144;
    localparam int SPAWN_Y       = 74;
    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;

    function automatic int lvl_width(input int num_levels);
        return (num_levels > 1) ? $clog2(num_levels) : 1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Handshake/status bundle between the game flow controller and the rest of
// the teeter top level (hole detector, ball mover, renderer, status display).
interface game_flow_ctrl_if #(
    parameter int PCB     = 10,
    parameter int LVL_W   = 2,
    parameter int LIVES_W = 2,
    parameter int TIMER_W = 12
) ();
    logic               i_restart;
    logic               i_screenend;
    logic               i_accel_ready;
    logic               i_win;
    logic               i_fail;
    logic [PCB-1:0]     i_roll_x;
    logic [PCB-1:0]     i_roll_y;
    logic [PCB-1:0]     i_fix_x;
    logic [PCB-1:0]     i_fix_y;
    logic [PCB-1:0]     o_bl_x;
    logic [PCB-1:0]     o_bl_y;
    logic               o_playing;
    logic               o_level_load;
    logic [LVL_W-1:0]   o_level;
    logic [LIVES_W-1:0] o_lives;
    logic [TIMER_W-1:0] o_time_left;
    logic [2:0]         o_state;
    logic               o_timeout;

    modport master (
        output i_restart, i_screenend, i_accel_ready, i_win, i_fail,
               i_roll_x, i_roll_y, i_fix_x, i_fix_y,
        input  o_bl_x, o_bl_y, o_playing, o_level_load, o_level,
               o_lives, o_time_left, o_state, o_timeout
    );

    modport slave (
        input  i_restart, i_screenend, i_accel_ready, i_win, i_fail,
               i_roll_x, i_roll_y, i_fix_x, i_fix_y,
        output o_bl_x, o_bl_y, o_playing, o_level_load, o_level,
               o_lives, o_time_left, o_state, o_timeout
    );
endinterface

// File: rtl/game_flow_ctrl_frame_timer.sv
// Frame down-counter: loads a value, decrements once per frame pulse and
// saturates at zero; expire flags the pulse that takes it from 1 to 0.
module game_flow_ctrl_frame_timer #(
    parameter int                 TIMER_W = 12,
    parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic [TIMER_W-1:0] cnt,
    output logic               expire
);
    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1'b1);

    logic [TIMER_W-1:0] cnt_r;

    // Load has priority so a pulse in a reload cycle never counts twice.
    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt_r <= RST_VAL;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (tick && (cnt_r != '0)) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt    = cnt_r;
    assign expire = tick && (cnt_r == ONE);

endmodule

// File: rtl/game_flow_ctrl.sv
// Multi-level teeter game flow: lives, per-attempt time limit, frame-timed
// countdown and result-hold phases, and the registered ball-position mux.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int PIXEL_COORD_BIT    = 10,
    parameter int NUM_LEVELS         = 4,
    parameter int START_LIVES        = 3,
    parameter int LIVES_W            = 2,
    parameter int COUNTDOWN_FRAMES   = 60,
    parameter int RESULT_HOLD_FRAMES = 90,
    parameter int LEVEL_TIME_FRAMES  = 1800,
    parameter int TIMER_W            = 12,
    parameter int SPAWN_POS_X        = SPAWN_X,
    parameter int SPAWN_POS_Y        = SPAWN_Y
) (
    input  logic            CLK,
    input  logic            rst,
    game_flow_ctrl_if.slave gif
);
    localparam int PCB   = PIXEL_COORD_BIT;
    localparam int LVL_W = lvl_width(NUM_LEVELS);

    localparam logic [TIMER_W-1:0] CD_LOAD    = TIMER_W'(COUNTDOWN_FRAMES);
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(RESULT_HOLD_FRAMES);
    localparam logic [TIMER_W-1:0] LVL_LOAD   = TIMER_W'(LEVEL_TIME_FRAMES);
    localparam logic [PCB-1:0]     SPX        = PCB'(SPAWN_POS_X);
    localparam logic [PCB-1:0]     SPY        = PCB'(SPAWN_POS_Y);
    localparam logic [LVL_W-1:0]   LAST_LVL   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LVL_W-1:0]   LVL_ONE    = LVL_W'(1'b1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] LIFE_ONE   = LIVES_W'(1'b1);

    state_t             state_r, next_state_s;
    logic               reset_s;
    logic               phase_load_s, phase_tick_s, phase_exp_s, phase_done_s;
    logic [TIMER_W-1:0] phase_val_s, phase_cnt_s;
    logic               lvl_tick_s, lvl_exp_s;
    logic [TIMER_W-1:0] lvl_cnt_s;
    logic               timeout_hit_s, playing_s, load_s;
    logic [PCB-1:0]     bl_x_s, bl_y_s;
    logic [PCB-1:0]     bl_x_r, bl_y_r, lat_x_r, lat_y_r;
    logic               ready_seen_r, timeout_r, playing_r, load_r;
    logic [LVL_W-1:0]   level_r;
    logic [LIVES_W-1:0] lives_r;

    assign reset_s       = rst | gif.i_restart;
    assign phase_load_s  = (next_state_s != state_r);
    assign phase_tick_s  = gif.i_screenend && ((state_r == ST_COUNTDOWN) ||
                           (state_r == ST_FAIL_HOLD) || (state_r == ST_WIN_HOLD));
    assign phase_done_s  = phase_exp_s || (phase_cnt_s == '0);
    assign lvl_tick_s    = gif.i_screenend && (state_r == ST_PLAYING);
    assign timeout_hit_s = (state_r == ST_PLAYING) && !gif.i_fail && !gif.i_win && lvl_exp_s;

    // Phase timer reload value chosen by the state being entered.
    always_comb begin
        phase_val_s = '0;
        case (next_state_s)
            ST_COUNTDOWN:             phase_val_s = CD_LOAD;
            ST_FAIL_HOLD, ST_WIN_HOLD: phase_val_s = HOLD_LOAD;
            default:                  phase_val_s = '0;
        endcase
    end

    game_flow_ctrl_frame_timer #(.TIMER_W(TIMER_W), .RST_VAL('0)) u_phase_tmr (
        .CLK(CLK), .rst(reset_s), .load(phase_load_s), .load_val(phase_val_s),
        .tick(phase_tick_s), .cnt(phase_cnt_s), .expire(phase_exp_s)
    );

    game_flow_ctrl_frame_timer #(.TIMER_W(TIMER_W), .RST_VAL(LVL_LOAD)) u_level_tmr (
        .CLK(CLK), .rst(reset_s), .load(state_r == ST_RESETING), .load_val(LVL_LOAD),
        .tick(lvl_tick_s), .cnt(lvl_cnt_s), .expire(lvl_exp_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (reset_s) begin
            state_r <= ST_RESETING;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; in PLAYING a hole fail beats a win, which beats timer expiry.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RESETING:  next_state_s = ST_COUNTDOWN;
            ST_COUNTDOWN: begin
                if (phase_done_s && (ready_seen_r || gif.i_accel_ready)) begin
                    next_state_s = ST_PLAYING;
                end else begin
                    next_state_s = ST_COUNTDOWN;
                end
            end
            ST_PLAYING: begin
                if (gif.i_fail)      next_state_s = ST_FAIL_HOLD;
                else if (gif.i_win)  next_state_s = ST_WIN_HOLD;
                else if (lvl_exp_s)  next_state_s = ST_FAIL_HOLD;
                else                 next_state_s = ST_PLAYING;
            end
            ST_FAIL_HOLD: begin
                if (!phase_done_s)           next_state_s = ST_FAIL_HOLD;
                else if (lives_r <= LIFE_ONE) next_state_s = ST_GAME_OVER;
                else                         next_state_s = ST_RESETING;
            end
            ST_WIN_HOLD: begin
                if (!phase_done_s)            next_state_s = ST_WIN_HOLD;
                else if (level_r == LAST_LVL) next_state_s = ST_COMPLETE;
                else                          next_state_s = ST_RESETING;
            end
            ST_GAME_OVER: next_state_s = ST_GAME_OVER;
            ST_COMPLETE:  next_state_s = ST_COMPLETE;
            default:      next_state_s = ST_RESETING;
        endcase
    end

    // Output decode; level_load trails RESETING by one cycle so o_level is already settled.
    always_comb begin
        playing_s = (next_state_s == ST_PLAYING);
        load_s    = (state_r == ST_RESETING);
        bl_x_s    = SPX;
        bl_y_s    = SPY;
        case (state_r)
            ST_PLAYING: begin
                bl_x_s = gif.i_roll_x;
                bl_y_s = gif.i_roll_y;
            end
            ST_FAIL_HOLD, ST_WIN_HOLD: begin
                if (timeout_r) begin
                    bl_x_s = lat_x_r;
                    bl_y_s = lat_y_r;
                end else begin
                    bl_x_s = gif.i_fix_x;
                    bl_y_s = gif.i_fix_y;
                end
            end
            ST_GAME_OVER, ST_COMPLETE: begin
                bl_x_s = bl_x_r;
                bl_y_s = bl_y_r;
            end
            default: begin
                bl_x_s = SPX;
                bl_y_s = SPY;
            end
        endcase
    end

    // Registered outputs, lives/level bookkeeping and the timeout ball latch.
    always_ff @(posedge CLK) begin
        if (reset_s) begin
            bl_x_r       <= SPX;
            bl_y_r       <= SPY;
            lat_x_r      <= SPX;
            lat_y_r      <= SPY;
            ready_seen_r <= 1'b0;
            timeout_r    <= 1'b0;
            playing_r    <= 1'b0;
            load_r       <= 1'b0;
            level_r      <= '0;
            lives_r      <= LIVES_INIT;
        end else begin
            bl_x_r    <= bl_x_s;
            bl_y_r    <= bl_y_s;
            playing_r <= playing_s;
            load_r    <= load_s;
            if (state_r != ST_COUNTDOWN)  ready_seen_r <= 1'b0;
            else if (gif.i_accel_ready)   ready_seen_r <= 1'b1;
            else                          ready_seen_r <= ready_seen_r;
            if (state_r == ST_RESETING)   timeout_r <= 1'b0;
            else if (timeout_hit_s)       timeout_r <= 1'b1;
            else                          timeout_r <= timeout_r;
            if (timeout_hit_s) begin
                lat_x_r <= gif.i_roll_x;
                lat_y_r <= gif.i_roll_y;
            end else begin
                lat_x_r <= lat_x_r;
                lat_y_r <= lat_y_r;
            end
            if ((state_r == ST_FAIL_HOLD) && phase_done_s && (lives_r != '0)) lives_r <= lives_r - LIFE_ONE;
            else                                                               lives_r <= lives_r;
            if ((state_r == ST_WIN_HOLD) && phase_done_s && (level_r != LAST_LVL)) level_r <= level_r + LVL_ONE;
            else                                                                    level_r <= level_r;
        end
    end

    assign gif.o_bl_x       = bl_x_r;
    assign gif.o_bl_y       = bl_y_r;
    assign gif.o_playing    = playing_r;
    assign gif.o_level_load = load_r;
    assign gif.o_level      = level_r;
    assign gif.o_lives      = lives_r;
    assign gif.o_time_left  = lvl_cnt_s;
    assign gif.o_state      = state_r;
    assign gif.o_timeout    = timeout_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: countdown, fail/win holds, timeout,
// game over, completion, restart and mid-hold reset.
module tb_game_flow_ctrl;
    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    game_flow_ctrl_if #(.PCB(10), .LVL_W(2), .LIVES_W(2), .TIMER_W(12)) gif ();

    game_flow_ctrl #(
        .PIXEL_COORD_BIT(10), .NUM_LEVELS(4), .START_LIVES(3), .LIVES_W(2),
        .COUNTDOWN_FRAMES(60), .RESULT_HOLD_FRAMES(90), .LEVEL_TIME_FRAMES(5),
        .TIMER_W(12), .SPAWN_POS_X(144), .SPAWN_POS_Y(74)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .gif(gif)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            gif.i_screenend = 1'b1;
            tick();
            gif.i_screenend = 1'b0;
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        gif.i_restart     = 1'b0;
        gif.i_screenend   = 1'b0;
        gif.i_accel_ready = 1'b1;
        gif.i_win         = 1'b0;
        gif.i_fail        = 1'b0;
        gif.i_roll_x      = 10'd50;
        gif.i_roll_y      = 10'd60;
        gif.i_fix_x       = 10'd10;
        gif.i_fix_y       = 10'd130;
        tick(); tick(); tick();
        check("rst_state", gif.o_state, 32'd0);
        check("rst_level", gif.o_level, 32'd0);
        check("rst_lives", gif.o_lives, 32'd3);
        check("rst_time", gif.o_time_left, 32'd5);
        check("rst_blx", gif.o_bl_x, 32'd144);
        check("rst_bly", gif.o_bl_y, 32'd74);
        check("rst_play", gif.o_playing, 32'd0);
        check("rst_load", gif.o_level_load, 32'd0);
        check("rst_tmo", gif.o_timeout, 32'd0);

        // countdown with ready high
        rst = 1'b0;
        tick();
        check("load_pulse", gif.o_level_load, 32'd1);
        check("cd_state", gif.o_state, 32'd1);
        tick();
        check("load_end", gif.o_level_load, 32'd0);
        frames(59);
        check("cd59_state", gif.o_state, 32'd1);
        check("cd59_play", gif.o_playing, 32'd0);
        check("cd59_blx", gif.o_bl_x, 32'd144);
        frames(1);
        check("cd60_state", gif.o_state, 32'd2);
        check("cd60_play", gif.o_playing, 32'd1);
        check("roll_blx", gif.o_bl_x, 32'd50);
        check("roll_bly", gif.o_bl_y, 32'd60);

        // hole fail and hold
        gif.i_fail = 1'b1;
        tick();
        gif.i_fail = 1'b0;
        check("fail_state", gif.o_state, 32'd3);
        check("fail_play", gif.o_playing, 32'd0);
        tick();
        check("fix_blx", gif.o_bl_x, 32'd10);
        check("fix_bly", gif.o_bl_y, 32'd130);
        frames(89);
        check("hold89_lives", gif.o_lives, 32'd3);
        check("hold89_state", gif.o_state, 32'd3);
        frames(1);
        check("hold_lives", gif.o_lives, 32'd2);
        check("hold_state", gif.o_state, 32'd1);
        check("hold_load", gif.o_level_load, 32'd1);

        // countdown waits for ready
        gif.i_accel_ready = 1'b0;
        frames(80);
        check("noready_state", gif.o_state, 32'd1);
        check("noready_play", gif.o_playing, 32'd0);
        gif.i_accel_ready = 1'b1;
        tick();
        check("ready_state", gif.o_state, 32'd2);

        // fail and win together: fail wins
        gif.i_fail = 1'b1;
        gif.i_win  = 1'b1;
        tick();
        gif.i_fail = 1'b0;
        gif.i_win  = 1'b0;
        check("fw_state", gif.o_state, 32'd3);
        frames(90);
        check("fw_lives", gif.o_lives, 32'd1);

        // win on level 0
        frames(60);
        gif.i_fix_x = 10'd200;
        gif.i_fix_y = 10'd20;
        gif.i_win   = 1'b1;
        tick();
        gif.i_win   = 1'b0;
        check("win_state", gif.o_state, 32'd4);
        tick();
        check("win_blx", gif.o_bl_x, 32'd200);
        frames(90);
        check("win_level", gif.o_level, 32'd1);
        check("win_load", gif.o_level_load, 32'd1);
        check("win_lives", gif.o_lives, 32'd1);
        for (int lv = 1; lv < 3; lv++) begin
            frames(60);
            gif.i_win = 1'b1;
            tick();
            gif.i_win = 1'b0;
            frames(90);
            check("lvl_adv", gif.o_level, lv + 1);
        end
        frames(60);
        gif.i_win = 1'b1;
        tick();
        gif.i_win = 1'b0;
        frames(90);
        check("cmp_state", gif.o_state, 32'd6);
        check("cmp_level", gif.o_level, 32'd3);
        gif.i_fix_x = 10'd1;
        gif.i_fix_y = 10'd2;
        frames(2);
        check("cmp_hold_blx", gif.o_bl_x, 32'd200);
        check("cmp_state2", gif.o_state, 32'd6);

        // restart
        gif.i_restart = 1'b1;
        tick();
        check("rs_state", gif.o_state, 32'd0);
        check("rs_level", gif.o_level, 32'd0);
        check("rs_lives", gif.o_lives, 32'd3);
        gif.i_restart = 1'b0;
        tick();
        check("rs_load", gif.o_level_load, 32'd1);

        // timer expiry
        frames(60);
        gif.i_roll_x = 10'd77;
        gif.i_roll_y = 10'd88;
        frames(4);
        check("t4_time", gif.o_time_left, 32'd1);
        check("t4_state", gif.o_state, 32'd2);
        gif.i_screenend = 1'b1;
        tick();
        gif.i_screenend = 1'b0;
        check("to_state", gif.o_state, 32'd3);
        check("to_flag", gif.o_timeout, 32'd1);
        check("to_time", gif.o_time_left, 32'd0);
        gif.i_roll_x = 10'd5;
        gif.i_roll_y = 10'd5;
        tick();
        check("to_blx", gif.o_bl_x, 32'd77);
        check("to_bly", gif.o_bl_y, 32'd88);
        frames(90);
        check("to_lives", gif.o_lives, 32'd2);
        check("to_clear", gif.o_timeout, 32'd0);
        check("to_reload", gif.o_time_left, 32'd5);

        // second fail
        frames(60);
        gif.i_fail = 1'b1;
        tick();
        gif.i_fail = 1'b0;
        frames(90);
        check("f2_lives", gif.o_lives, 32'd1);

        // fail coinciding with expiry, last life
        frames(60);
        frames(4);
        gif.i_fail      = 1'b1;
        gif.i_screenend = 1'b1;
        tick();
        gif.i_fail      = 1'b0;
        gif.i_screenend = 1'b0;
        check("fe_state", gif.o_state, 32'd3);
        check("fe_tmo", gif.o_timeout, 32'd0);
        check("fe_time", gif.o_time_left, 32'd0);
        frames(90);
        check("go_state", gif.o_state, 32'd5);
        check("go_lives", gif.o_lives, 32'd0);
        gif.i_fix_x = 10'd9;
        frames(5);
        check("go_hold_lives", gif.o_lives, 32'd0);
        check("go_hold_blx", gif.o_bl_x, 32'd1);

        // restart, then rst in the middle of a win hold
        gif.i_restart = 1'b1;
        tick();
        gif.i_restart = 1'b0;
        check("rs2_lives", gif.o_lives, 32'd3);
        tick();
        frames(60);
        gif.i_win = 1'b1;
        tick();
        gif.i_win = 1'b0;
        frames(40);
        check("mid_state", gif.o_state, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", gif.o_state, 32'd0);
        check("mid_rst_level", gif.o_level, 32'd0);
        check("mid_rst_lives", gif.o_lives, 32'd3);
        check("mid_rst_blx", gif.o_bl_x, 32'd144);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
